// File: rtl/snake_core_ring.sv
// Snake body ring: head stepping, growth, border handling and game-over FSM.
// Define SNAKE_SELF_COLLIDE_EN to add the post-move self-collision SCAN.
module snake_core_ring #(
    parameter int unsigned CELL         = 10,
    parameter int unsigned GRID_W       = 64,
    parameter int unsigned GRID_H       = 48,
    parameter int unsigned MAX_LEN      = 33,
    parameter int unsigned START_LEN    = 3,
    parameter int unsigned GROW_PER_EAT = 1,
    parameter int unsigned WRAP         = 0
) (
    input  logic                  clk_pix,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic [1:0]            dir,
    input  logic                  eat_evt,
    input  logic                  restart,
    output logic [9:0]            head_x,
    output logic [8:0]            head_y,
    output logic [7:0]            length,
    output logic [MAX_LEN*10-1:0] body_bus_x,
    output logic [MAX_LEN*9-1:0]  body_bus_y,
    output logic                  alive,
    output logic                  busy
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned LW = 8;
    localparam int unsigned GW = 8;
    localparam int unsigned X0 = 370;
    localparam int unsigned Y0 = 280;

    localparam logic [XW-1:0] CELL_X      = XW'(CELL);
    localparam logic [YW-1:0] CELL_Y      = YW'(CELL);
    localparam logic [XW-1:0] XMAX        = XW'((GRID_W - 2) * CELL);
    localparam logic [YW-1:0] YMAX        = YW'((GRID_H - 2) * CELL);
    localparam logic [YW-1:0] Y0_P        = YW'(Y0);
    localparam logic [LW-1:0] MAX_LEN_L   = LW'(MAX_LEN);
    localparam logic [LW-1:0] START_LEN_L = LW'(START_LEN);
    localparam logic [GW:0]   GROW_INC    = (GW+1)'(GROW_PER_EAT);
    localparam bit            WRAP_EN     = (WRAP != 0);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SCAN, S_DEAD} state_e;

    // Start column of slot k; slots past the start length sit on the tail.
    function automatic logic [XW-1:0] init_x(input int unsigned k);
        int unsigned kk;
        kk = (k < START_LEN) ? k : START_LEN - 1;
        return XW'(X0 - CELL * kk);
    endfunction

    state_e        state_q, state_d;
    logic [1:0]    heading_q, heading_d;
    logic [LW-1:0] length_q, length_d;
    logic [GW-1:0] grow_q, grow_d;
    logic          alive_q, alive_d;
    logic          busy_q, busy_d;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];
`ifdef SNAKE_SELF_COLLIDE_EN
    logic [LW-1:0] idx_q, idx_d;
    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;
`endif

    logic [XW-1:0] step_x;
    logic [YW-1:0] step_y;
    logic          step_fatal;
    logic          grow_en;
    logic [LW-1:0] new_len;
    logic [XW-1:0] tail_x;
    logic [YW-1:0] tail_y;
    logic [GW:0]   grow_sum;

    // Candidate head position one cell along the current heading.
    always_comb begin
        step_x     = seg_x_q[0];
        step_y     = seg_y_q[0];
        step_fatal = 1'b0;
        case (heading_q)
            DIR_UP: begin
                if (seg_y_q[0] > CELL_Y) step_y = seg_y_q[0] - CELL_Y;
                else if (WRAP_EN)        step_y = YMAX;
                else                     step_fatal = 1'b1;
            end
            DIR_LEFT: begin
                if (seg_x_q[0] > CELL_X) step_x = seg_x_q[0] - CELL_X;
                else if (WRAP_EN)        step_x = XMAX;
                else                     step_fatal = 1'b1;
            end
            DIR_DOWN: begin
                if (seg_y_q[0] < YMAX)   step_y = seg_y_q[0] + CELL_Y;
                else if (WRAP_EN)        step_y = CELL_Y;
                else                     step_fatal = 1'b1;
            end
            default: begin
                if (seg_x_q[0] < XMAX)   step_x = seg_x_q[0] + CELL_X;
                else if (WRAP_EN)        step_x = CELL_X;
                else                     step_fatal = 1'b1;
            end
        endcase
    end

    // Next-state, body shift, growth bookkeeping and restart override.
    always_comb begin
        state_d   = state_q;
        heading_d = heading_q;
        length_d  = length_q;
        grow_d    = grow_q;
        alive_d   = alive_q;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            seg_x_d[k] = seg_x_q[k];
            seg_y_d[k] = seg_y_q[k];
        end
        grow_en  = (grow_q != '0) && (length_q < MAX_LEN_L);
        new_len  = length_q + LW'(grow_en);
        tail_x   = seg_x_q[0];
        tail_y   = seg_y_q[0];
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (LW'(k) == new_len - LW'(2)) begin
                tail_x = seg_x_q[k];
                tail_y = seg_y_q[k];
            end
        end
        grow_sum = '0;
`ifdef SNAKE_SELF_COLLIDE_EN
        idx_d  = idx_q;
        scan_x = seg_x_q[0];
        scan_y = seg_y_q[0];
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (LW'(k) == idx_q) begin
                scan_x = seg_x_q[k];
                scan_y = seg_y_q[k];
            end
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (tick && alive_q) begin
                    if (dir != (heading_q ^ 2'd2)) heading_d = dir;
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                if (step_fatal) begin
                    state_d = S_DEAD;
                    alive_d = 1'b0;
                end else begin
                    // Slot new_len-1 receives the old tail when growing.
                    for (int unsigned k = 1; k < MAX_LEN; k++) begin
                        if (LW'(k) < new_len) begin
                            seg_x_d[k] = seg_x_q[k-1];
                            seg_y_d[k] = seg_y_q[k-1];
                        end else begin
                            seg_x_d[k] = tail_x;
                            seg_y_d[k] = tail_y;
                        end
                    end
                    seg_x_d[0] = step_x;
                    seg_y_d[0] = step_y;
                    length_d   = new_len;
                    if (grow_en) grow_d = grow_q - GW'(1);
`ifdef SNAKE_SELF_COLLIDE_EN
                    state_d = S_SCAN;
                    idx_d   = LW'(1);
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef SNAKE_SELF_COLLIDE_EN
            S_SCAN: begin
                if ((scan_x == seg_x_q[0]) && (scan_y == seg_y_q[0])) begin
                    state_d = S_DEAD;
                    alive_d = 1'b0;
                end else if (idx_q == length_q - LW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
`endif
            S_DEAD: ;
            default: state_d = S_IDLE;
        endcase

        if (eat_evt) begin
            grow_sum = {1'b0, grow_d} + GROW_INC;
            grow_d   = grow_sum[GW] ? {GW{1'b1}} : grow_sum[GW-1:0];
        end
        if (length_d == MAX_LEN_L) grow_d = '0;

        if (restart) begin
            state_d   = S_IDLE;
            heading_d = DIR_RIGHT;
            length_d  = START_LEN_L;
            grow_d    = '0;
            alive_d   = 1'b1;
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                seg_x_d[k] = init_x(k);
                seg_y_d[k] = Y0_P;
            end
`ifdef SNAKE_SELF_COLLIDE_EN
            idx_d = LW'(1);
`endif
        end
        busy_d = (state_d == S_MOVE) || (state_d == S_SCAN);
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            heading_q <= DIR_RIGHT;
            length_q  <= START_LEN_L;
            grow_q    <= '0;
            alive_q   <= 1'b1;
            busy_q    <= 1'b0;
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                seg_x_q[k] <= init_x(k);
                seg_y_q[k] <= Y0_P;
            end
`ifdef SNAKE_SELF_COLLIDE_EN
            idx_q <= LW'(1);
`endif
        end else begin
            state_q   <= state_d;
            heading_q <= heading_d;
            length_q  <= length_d;
            grow_q    <= grow_d;
            alive_q   <= alive_d;
            busy_q    <= busy_d;
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                seg_x_q[k] <= seg_x_d[k];
                seg_y_q[k] <= seg_y_d[k];
            end
`ifdef SNAKE_SELF_COLLIDE_EN
            idx_q <= idx_d;
`endif
        end
    end

    assign head_x = seg_x_q[0];
    assign head_y = seg_y_q[0];
    assign length = length_q;
    assign alive  = alive_q;
    assign busy   = busy_q;

    // Head occupies the most significant slot of each bus.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_bus
        assign body_bus_x[(MAX_LEN-1-g)*XW +: XW] = seg_x_q[g];
        assign body_bus_y[(MAX_LEN-1-g)*YW +: YW] = seg_y_q[g];
    end

endmodule

// File: tb/tb_snake_core_ring.sv
// Directed self-checking bench for snake_core_ring: a lethal-border instance
// growing by 2 per eat and a wrapping instance growing by 1, sharing stimulus.
module tb_snake_core_ring;

    localparam int ML = 33;

    logic           clk_pix = 1'b0;
    logic           reset_n;
    logic           tick;
    logic [1:0]     dir;
    logic           eat_evt;
    logic           restart;

    logic [9:0]     a_head_x, w_head_x;
    logic [8:0]     a_head_y, w_head_y;
    logic [7:0]     a_length, w_length;
    logic [ML*10-1:0] a_bus_x, w_bus_x;
    logic [ML*9-1:0]  a_bus_y, w_bus_y;
    logic           a_alive, w_alive;
    logic           a_busy, w_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int nb;

    always #5 clk_pix = ~clk_pix;

    snake_core_ring #(.MAX_LEN(ML), .GROW_PER_EAT(2), .WRAP(0)) u_dut (
        .clk_pix(clk_pix), .reset_n(reset_n), .tick(tick), .dir(dir),
        .eat_evt(eat_evt), .restart(restart),
        .head_x(a_head_x), .head_y(a_head_y), .length(a_length),
        .body_bus_x(a_bus_x), .body_bus_y(a_bus_y),
        .alive(a_alive), .busy(a_busy)
    );

    snake_core_ring #(.MAX_LEN(ML), .GROW_PER_EAT(1), .WRAP(1)) u_wrap (
        .clk_pix(clk_pix), .reset_n(reset_n), .tick(tick), .dir(dir),
        .eat_evt(eat_evt), .restart(restart),
        .head_x(w_head_x), .head_y(w_head_y), .length(w_length),
        .body_bus_x(w_bus_x), .body_bus_y(w_bus_y),
        .alive(w_alive), .busy(w_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] slot_x(input logic [ML*10-1:0] b, input int k);
        return b[(ML-1-k)*10 +: 10];
    endfunction

    function automatic logic [8:0] slot_y(input logic [ML*9-1:0] b, input int k);
        return b[(ML-1-k)*9 +: 9];
    endfunction

    // Wait for both instances to go idle, counting busy cycles of u_dut.
    task automatic wait_idle(output int n);
        n = 0;
        for (int c = 0; c < 200 && (a_busy || w_busy); c++) begin
            if (a_busy) n++;
            @(negedge clk_pix);
        end
        check_eq("idle_timeout", 32'(a_busy | w_busy), 0);
    endtask

    task automatic do_tick(input logic [1:0] d, output int n);
        @(negedge clk_pix);
        dir  = d;
        tick = 1'b1;
        @(negedge clk_pix);
        tick = 1'b0;
        wait_idle(n);
    endtask

    task automatic pulse_eat();
        @(negedge clk_pix);
        eat_evt = 1'b1;
        @(negedge clk_pix);
        eat_evt = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk_pix);
        restart = 1'b1;
        @(negedge clk_pix);
        restart = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_hx"},    a_head_x, 370);
        check_eq({tag, "_hy"},    a_head_y, 280);
        check_eq({tag, "_len"},   a_length, 3);
        check_eq({tag, "_alive"}, a_alive, 1);
        check_eq({tag, "_busy"},  a_busy, 0);
        check_eq({tag, "_s1x"},   slot_x(a_bus_x, 1), 360);
        check_eq({tag, "_s2x"},   slot_x(a_bus_x, 2), 350);
        check_eq({tag, "_slx"},   slot_x(a_bus_x, ML-1), 350);
        check_eq({tag, "_sly"},   slot_y(a_bus_y, ML-1), 280);
        check_eq({tag, "_whx"},   w_head_x, 370);
        check_eq({tag, "_wlen"},  w_length, 3);
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b0;
        dir     = 2'd3;
        eat_evt = 1'b0;
        restart = 1'b0;
        repeat (3) @(negedge clk_pix);
        check_reset("por");
        reset_n = 1'b1;
        @(negedge clk_pix);

        // Three steps right from (370,280).
        repeat (3) do_tick(2'd3, nb);
        check_eq("r3_hx", a_head_x, 400);
        check_eq("r3_hy", a_head_y, 280);
        check_eq("r3_len", a_length, 3);
        check_eq("r3_alive", a_alive, 1);
        check_eq("r3_whx", w_head_x, 400);

        // LEFT while heading RIGHT is a reversal and is ignored.
        do_tick(2'd1, nb);
        check_eq("rev_hx", a_head_x, 410);
        check_eq("rev_hy", a_head_y, 280);

        // Growth: body is 410,400,390 before the eat.
        pulse_eat();
        do_tick(2'd3, nb);
        check_eq("g1_len", a_length, 4);
        check_eq("g1_tail", slot_x(a_bus_x, 3), 390);
        check_eq("g1_wlen", w_length, 4);
        do_tick(2'd3, nb);
        check_eq("g2_len", a_length, 5);
        check_eq("g2_tail", slot_x(a_bus_x, 4), 390);
        do_tick(2'd3, nb);
        check_eq("g3_len", a_length, 5);
        check_eq("g3_tail", slot_x(a_bus_x, 4), 400);
        check_eq("g3_pad", slot_x(a_bus_x, ML-1), 400);
        check_eq("g3_hx", a_head_x, 440);
        check_eq("g3_wlen", w_length, 4);

        // Run to the right border at x=620, then one more step.
        repeat (18) do_tick(2'd3, nb);
        check_eq("edge_hx", a_head_x, 620);
        check_eq("edge_alive", a_alive, 1);
        check_eq("edge_whx", w_head_x, 620);
        do_tick(2'd3, nb);
        check_eq("die_alive", a_alive, 0);
        check_eq("die_hx", a_head_x, 620);
        check_eq("wrap_hx", w_head_x, 10);
        check_eq("wrap_hy", w_head_y, 280);
        check_eq("wrap_alive", w_alive, 1);
        do_tick(2'd3, nb);
        check_eq("dead_hx", a_head_x, 620);
        check_eq("dead_busy", nb, 0);
        check_eq("dead_alive", a_alive, 0);
        check_eq("wrap2_hx", w_head_x, 20);

        pulse_restart();
        check_reset("rst_dead");

        // Length-5 body, then UP/LEFT/DOWN loop back onto seg4 at (380,280).
        pulse_eat();
        do_tick(2'd3, nb);
        do_tick(2'd3, nb);
        check_eq("sc_len", a_length, 5);
        check_eq("sc_hx0", a_head_x, 390);
        do_tick(2'd0, nb);
        do_tick(2'd1, nb);
        do_tick(2'd2, nb);
        check_eq("sc_hx", a_head_x, 380);
        check_eq("sc_hy", a_head_y, 280);
        check_eq("sc_walive", w_alive, 1);
`ifdef SNAKE_SELF_COLLIDE_EN
        check_eq("sc_busy_cyc", nb, 5);
        check_eq("sc_alive", a_alive, 0);
        do_tick(2'd3, nb);
        check_eq("sc_after_hx", a_head_x, 380);
        check_eq("sc_after_alive", a_alive, 0);
`else
        check_eq("sc_busy_cyc", nb, 1);
        check_eq("sc_alive", a_alive, 1);
        do_tick(2'd3, nb);
        check_eq("sc_after_hx", a_head_x, 390);
        check_eq("sc_after_alive", a_alive, 1);
`endif

        pulse_restart();
        check_reset("rst2");

        // Asynchronous reset two edges after an accepted tick.
        @(negedge clk_pix);
        dir  = 2'd3;
        tick = 1'b1;
        @(negedge clk_pix);
        tick = 1'b0;
        @(negedge clk_pix);
        check_eq("mid_hx", a_head_x, 380);
`ifdef SNAKE_SELF_COLLIDE_EN
        check_eq("mid_busy", a_busy, 1);
`endif
        reset_n = 1'b0;
        #1;
        check_reset("async");
        @(negedge clk_pix);
        reset_n = 1'b1;
        @(negedge clk_pix);
        check_eq("post_busy", a_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_core_ring.md
SNAKE_CORE_RING -- requirements
Module: snake_core_ring

Interface
REQ-001 SHALL have parameter CELL, default 10: cell size in pixels.
REQ-002 SHALL have parameter GRID_W, default 64: playfield width in cells, border included.
REQ-003 SHALL have parameter GRID_H, default 48: playfield height in cells, border included.
REQ-004 SHALL have parameter MAX_LEN, default 33: maximum segments including head, range 4..255.
REQ-005 SHALL have parameter START_LEN, default 3: length after reset or restart, range 2..MAX_LEN.
REQ-006 SHALL have parameter GROW_PER_EAT, default 1: segments added per eat event, range 1..15.
REQ-007 SHALL have parameter WRAP, default 0: 0 = border is lethal, 1 = toroidal wrap.
REQ-008 SHALL have port clk_pix, input, 1 bit: the single clock.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port tick, input, 1 bit: one-cycle move strobe.
REQ-011 SHALL have port dir, input, 2 bits: 0=UP, 1=LEFT, 2=DOWN, 3=RIGHT.
REQ-012 SHALL have port eat_evt, input, 1 bit: one-cycle eat pulse.
REQ-013 SHALL have port restart, input, 1 bit: one-cycle synchronous re-init pulse.
REQ-014 SHALL have outputs head_x (10 bits) and head_y (9 bits): head pixel position.
REQ-015 SHALL have output length, 8 bits: active segment count.
REQ-016 SHALL have outputs body_bus_x (MAX_LEN*10 bits) and body_bus_y (MAX_LEN*9 bits): segments packed MSB-first, seg0 = head; inactive slots repeat the tail position.
REQ-017 SHALL have output alive, 1 bit: 0 after a fatal collision.
REQ-018 SHALL have output busy, 1 bit: 1 while a move or scan is in progress.

Function
REQ-019 SHALL limit the playable area to x in [CELL, (GRID_W-2)*CELL] and y in [CELL, (GRID_H-2)*CELL].
REQ-020 SHALL implement FSM states IDLE, MOVE, SCAN, DEAD.
REQ-021 SHALL accept tick only in IDLE with alive=1; a tick in any other state SHALL be dropped.
REQ-022 SHALL register the effective heading on an accepted tick; a dir opposite to the current heading SHALL be ignored; the initial heading is RIGHT.
REQ-023 SHALL, in MOVE (1 cycle), shift segments k = length-1..1 from k-1 and step the head by CELL in the heading direction.
REQ-024 SHALL, when WRAP=1, move the head leaving max x to CELL and leaving CELL to max x (y likewise).
REQ-025 SHALL, when WRAP=0, treat a step outside the playable area as fatal: head not updated, state goes to DEAD, alive=0.
REQ-026 SHALL increment a saturating 8-bit grow_pending counter by GROW_PER_EAT per eat_evt.
REQ-027 SHALL, in MOVE with grow_pending>0 and length<MAX_LEN, copy the old tail to slot length, increment length, and decrement grow_pending.
REQ-028 SHALL, when eat_evt coincides with that MOVE decrement, apply both (net +GROW_PER_EAT-1).
REQ-029 SHALL clear grow_pending when length==MAX_LEN.
REQ-030 SHALL update head_x/head_y on the clock edge that leaves MOVE.
REQ-031 SHALL drive busy=1 in MOVE and SCAN and busy=0 otherwise.
REQ-032 SHALL make DEAD absorbing: only restart or reset leaves it.
REQ-033 SHALL, on restart in any state, re-initialise within 1 cycle to the reset values and enter IDLE; restart SHALL take priority over tick and eat_evt.

Reset
REQ-034 SHALL asynchronously set on reset_n low: seg0 = (370, 280), seg1..MAX_LEN-1 = (370-CELL*k, 280) for k < START_LEN and the tail position otherwise, length=START_LEN, heading RIGHT, grow_pending=0, alive=1, busy=0, state IDLE.

Configuration
REQ-035 SHALL, with SNAKE_SELF_COLLIDE_EN defined, run SCAN after MOVE, comparing the head against seg1..length-1 at one segment per cycle (length-1 cycles); any match SHALL cause DEAD, otherwise IDLE.
REQ-036 SHALL, without SNAKE_SELF_COLLIDE_EN, omit SCAN and its logic; MOVE SHALL return directly to IDLE and self-overlap SHALL never be fatal.

Verification
REQ-037 SHALL cover: reset, then 3 ticks with dir=3 -> head (400,280), length 3, alive=1.
REQ-038 SHALL cover: heading RIGHT, dir=1, tick -> head advances to x+10 (reversal ignored).
REQ-039 SHALL cover: eat_evt with GROW_PER_EAT=2, then 3 ticks -> length 3->4->5->5, new tail equals the previous tail.
REQ-040 SHALL cover: WRAP=1, head (620,280) moving RIGHT, tick -> head (10,280); WRAP=0 -> alive=0, head stays (620,280).
REQ-041 SHALL cover: SNAKE_SELF_COLLIDE_EN defined, length 5, UP/LEFT/DOWN loop into own body -> alive=0 after length-1 scan cycles; further ticks ignored.
REQ-042 SHALL cover: reset_n asserted mid-SCAN and restart asserted in DEAD -> all outputs at REQ-034 values, busy=0.
